// File: rtl/mem_access.sv
// mem_access: MEM stage of a simple in-order pipeline.
// Accepts one instruction at a time from EX and runs one bus transaction for a
// load or store. It forms byte enables, replicates store data across byte
// lanes, and extracts and extends load data.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently aligning them.
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] ALUout,
    input  logic [31:0] RegB,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSignExt,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] MemData,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_sext;
    logic        r_we;
    logic        r_both;

    logic        w_is_mem;
    logic        w_trap;
    logic        w_in_req;
    logic [3:0]  w_be;
    logic [31:0] w_wrep;
    logic [31:0] w_shift;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_is_mem = MemRead | MemWrite;
    assign w_in_req = (r_state == REQ);

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;
    assign w_trap   = ((MemSize == 2'b01) && ALUout[0]) ||
                      (MemSize[1] && (ALUout[1:0] != 2'b00));
    assign misalign = (r_state == DONE) & r_misalign;

    // Remember whether the instruction that led to DONE was trapped
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_misalign <= 1'b0;
        else if (r_state == IDLE && in_valid)
            r_misalign <= w_is_mem & w_trap;
    end
`else
    assign w_trap   = 1'b0;
    assign misalign = 1'b0;
`endif

    // Control FSM plus capture of the access operands on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_sext  <= 1'b0;
            r_we    <= 1'b0;
            r_both  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    if (w_is_mem && !w_trap) begin
                        r_state <= REQ;
                        r_addr  <= ALUout;
                        r_wdata <= RegB;
                        r_size  <= MemSize;
                        r_sext  <= MemSignExt;
                        // A simultaneous read+write is performed as a write
                        r_we    <= MemWrite;
                        r_both  <= MemRead & MemWrite;
                    end else begin
                        r_state <= DONE;
                    end
                end
                REQ:     if (mem_ack) r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Byte enables and lane-replicated store data from the latched operands
    always_comb begin
        w_be   = 4'b1111;
        w_wrep = r_wdata;
        case (r_size)
            2'b00: begin
                w_be   = 4'b0001 << r_addr[1:0];
                w_wrep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        w_shift = mem_rdata >> {r_addr[1:0], 3'b000};
        w_half  = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_sext & w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // Load result register: updated only when a load completes or a read+write or trap reports zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            MemData <= '0;
        else if (r_state == IDLE && in_valid && w_is_mem && w_trap)
            MemData <= '0;
        else if (w_in_req && mem_ack) begin
            if (!r_we)
                MemData <= w_load;
            else if (r_both)
                MemData <= '0;
        end
    end

    // Bus outputs are decoded from state, so reset drops mem_req immediately
    assign mem_req   = w_in_req;
    assign mem_we    = w_in_req & r_we;
    assign mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_be    = w_in_req ? w_be : 4'd0;
    assign mem_wdata = w_in_req ? w_wrep : 32'd0;

    assign out_valid = (r_state == DONE);
    assign stall     = ~reset & (((r_state == IDLE) & in_valid & w_is_mem) | w_in_req);

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios followed by random
// loads/stores against a byte-lane reference model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] ALUout, RegB;
    logic        MemRead, MemWrite;
    logic [1:0]  MemSize;
    logic        MemSignExt;
    logic        stall, out_valid, misalign;
    logic [31:0] MemData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_md = 32'd0;

    mem_access dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .ALUout(ALUout), .RegB(RegB),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSignExt(MemSignExt),
        .stall(stall), .out_valid(out_valid), .MemData(MemData), .misalign(misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One instruction, entered at a point where the DUT is IDLE and mid-cycle.
    // dly = number of REQ cycles before the one carrying mem_ack.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                          input int dly);
        logic        mem, trap;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        int          off, nb;
        longint      val, mask;
        mem  = rd | wr;
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = mem && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0));
`endif
        // Reference: bytes touched by the access, and where the loaded value comes from
        case (sz)
            2'd0:    begin nb = 1; off = int'(a[1:0]);    end
            2'd1:    begin nb = 2; off = a[1] ? 2 : 0;    end
            default: begin nb = 4; off = 0;               end
        endcase
        ebe = 4'd0;
        ewd = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) ebe[i] = 1'b1;
            ewd[8*i +: 8] = d[8*(i % nb) +: 8];
        end
        mask = (64'd1 << (8 * nb)) - 1;
        val  = (longint'(rdat) >> (8 * off)) & mask;
        if (sx && val[8*nb-1]) val = val | (~mask & 64'h0000_0000_FFFF_FFFF);

        in_valid = 1'b1; ALUout = a; RegB = d; MemRead = rd; MemWrite = wr;
        MemSize = sz; MemSignExt = sx;
        #1;
        chk("stall_accept", {31'd0, stall}, {31'd0, mem});
        chk("ov_idle", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        if (mem && !trap) begin
            for (int k = 0; k <= dly; k++) begin
                #1;
                chk("req", {31'd0, mem_req}, 32'd1);
                chk("we", {31'd0, mem_we}, {31'd0, wr});
                chk("addr", mem_addr, {a[31:2], 2'b00});
                chk("be", {28'd0, mem_be}, {28'd0, ebe});
                if (wr) chk("wdata", mem_wdata, ewd);
                chk("stall_req", {31'd0, stall}, 32'd1);
                chk("ov_req", {31'd0, out_valid}, 32'd0);
                if (k == dly) begin mem_ack = 1'b1; mem_rdata = rdat; end
                else mem_rdata = $urandom;
                @(posedge clk); #1;
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
        end
        in_valid = 1'b0;
        mem_ack  = 1'($urandom_range(0, 1));  // ack in DONE must be ignored
        #1;
        if (trap) exp_md = 32'd0;
        else if (mem) begin
            if (!wr) exp_md = val[31:0];
            else if (rd) exp_md = 32'd0;
        end
        chk("ov_done", {31'd0, out_valid}, 32'd1);
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("req_done", {31'd0, mem_req}, 32'd0);
        chk("memdata", MemData, exp_md);
        chk("misalign", {31'd0, misalign}, {31'd0, trap});
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1;
        chk("ov_after", {31'd0, out_valid}, 32'd0);
        chk("memdata_hold", MemData, exp_md);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; ALUout = '0; RegB = '0; MemRead = 1'b0; MemWrite = 1'b0;
        MemSize = '0; MemSignExt = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_md", MemData, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_bus", {mem_addr[31:1], mem_we} | mem_wdata | {28'd0, mem_be}, 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios
        run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        run_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80112233, 1);
        chk("ld_byte_sx", MemData, 32'hFFFFFF80);
        run_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80112233, 0);
        chk("ld_byte_zx", MemData, 32'h00000080);
        run_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h206, 32'h0000ABCD, 32'h0, 5);
        run_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 32'h0, 0);
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h12345678, 0);
        run_op(1'b1, 1'b1, 2'd2, 1'b0, 32'h300, 32'h55AA55AA, 32'hFFFFFFFF, 2);
        chk("rw_zero", MemData, 32'd0);

        // Reset in the middle of a bus request
        in_valid = 1'b1; ALUout = 32'h400; RegB = 32'h1; MemRead = 1'b0; MemWrite = 1'b1;
        MemSize = 2'd2;
        @(posedge clk); #2;
        chk("mid_req", {31'd0, mem_req}, 32'd1);
        #2; reset = 1'b1; #1;
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_ov", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0; exp_md = 32'd0;
        @(posedge clk); #1; reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_ack_ov", {31'd0, out_valid}, 32'd0);
            chk("late_ack_req", {31'd0, mem_req}, 32'd0);
            @(posedge clk); #1;
        end
        chk("late_ack_md", MemData, 32'd0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            run_op(op[0], op[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
